// File: rtl/sfx_pkg.sv
// Shared constants for the sound-effect scheduler: source ids, clip layout
// in the shared sample ROM, FSM state type and the 16-bit saturator.
package sfx_pkg;

  localparam int NUM_SFX = 4;

  localparam logic [1:0] SFX_HIT  = 2'd0;
  localparam logic [1:0] SFX_MISS = 2'd1;
  localparam logic [1:0] SFX_LVL  = 2'd2;
  localparam logic [1:0] SFX_OVER = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  // Clips are stored back to back; 16000 words in total.
  function automatic logic [15:0] clip_base(input logic [1:0] id);
    logic [15:0] b;
    case (id)
      SFX_HIT:  b = 16'd0;
      SFX_MISS: b = 16'd1600;
      SFX_LVL:  b = 16'd3200;
      default:  b = 16'd8000;
    endcase
    return b;
  endfunction

  function automatic logic [15:0] clip_len(input logic [1:0] id);
    logic [15:0] l;
    case (id)
      SFX_HIT:  l = 16'd1600;
      SFX_MISS: l = 16'd1600;
      SFX_LVL:  l = 16'd4800;
      default:  l = 16'd8000;
    endcase
    return l;
  endfunction

  // 17'sh07fff = +32767, 17'sh18000 = -32768.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    logic signed [15:0] r;
    if (s > 17'sh07fff)      r = 16'sh7fff;
    else if (s < 17'sh18000) r = 16'sh8000;
    else                     r = s[15:0];
    return r;
  endfunction

endpackage

// File: rtl/sfx_prio_enc.sv
// Priority encoder over the effect candidate set; the highest set index wins.
module sfx_prio_enc
  import sfx_pkg::*;
(
  input  logic [NUM_SFX-1:0] vec,
  output logic [1:0]         idx,
  output logic               valid
);

  always_comb begin
    idx   = 2'd0;
    valid = 1'b0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (vec[i]) begin
        idx   = 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates effect requests onto the shared clip ROM,
// steps addresses once per sample tick and mixes the clip over ducked music.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int SAMPLE_DIV = 31250,
  parameter int ROM_AW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic                sfx_en,
  input  logic signed [15:0]  bgm_sample,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic signed [15:0]  rom_data,
  output logic signed [15:0]  mix_out,
  output logic                sample_valid,
  output logic                sfx_busy,
  output logic [1:0]          playing_id,
  output logic                clip_done
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic [3:0]           pending_q, pending_d;
  logic [ROM_AW-1:0]    rom_addr_q, rom_addr_d;
  logic [15:0]          remaining_q, remaining_d;
  logic [1:0]           playing_id_q, playing_id_d;
  logic                 clip_done_q, clip_done_d;
  logic [2:0]           tick_pipe_q, tick_pipe_d;
  logic signed [15:0]   sfx_sample_q, sfx_sample_d;
  logic                 active_q, active_d;
  logic signed [15:0]   mix_q, mix_d;
  logic                 sample_valid_q, sample_valid_d;

  logic                 tick;
  logic                 do_load;
  logic [3:0]           play_mask;
  logic [3:0]           req_eff;
  logic [3:0]           cand;
  logic [1:0]           win_id;
  logic                 win_valid;
  logic signed [15:0]   bgm_eff;
  logic signed [16:0]   mix_sum;

  assign tick = (cnt_q == CNT_LAST);

  // A request for the clip already playing is dropped outright.
  assign play_mask = (state_q == ST_PLAY) ? (4'b0001 << playing_id_q) : 4'b0000;
  assign req_eff   = sfx_en ? (req & ~play_mask) : 4'b0000;
  assign cand      = sfx_en ? (pending_q | req_eff) : 4'b0000;

  sfx_prio_enc u_prio (
    .vec   (cand),
    .idx   (win_id),
    .valid (win_valid)
  );

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    state_d      = state_q;
    pending_d    = sfx_en ? (pending_q | req_eff) : 4'b0000;
    rom_addr_d   = rom_addr_q;
    remaining_d  = remaining_q;
    playing_id_d = playing_id_q;
    clip_done_d  = 1'b0;
    do_load      = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) do_load = 1'b1;
        end
        ST_PLAY: begin
          if (!sfx_en) begin
            state_d = ST_IDLE;
          end else if (win_valid && (win_id > playing_id_q)) begin
            do_load = 1'b1;
          end else if (remaining_q == '0) begin
            // Chain straight into the next queued clip with no silent period.
            clip_done_d = 1'b1;
            if (win_valid) do_load = 1'b1;
            else           state_d = ST_IDLE;
          end else begin
            rom_addr_d  = rom_addr_q + ROM_AW'(1);
            remaining_d = remaining_q - 16'd1;
          end
        end
      endcase
    end

    if (do_load) begin
      state_d           = ST_PLAY;
      rom_addr_d        = ROM_AW'(clip_base(win_id));
      remaining_d       = clip_len(win_id) - 16'd1;
      playing_id_d      = win_id;
      pending_d[win_id] = 1'b0;
    end
  end

  // Sample pipeline: address at E0, ROM data at E1, capture at E2, mix at E3.
  always_comb begin
    tick_pipe_d  = {tick_pipe_q[1:0], tick};
    sfx_sample_d = sfx_sample_q;
    active_d     = active_q;
    if (tick_pipe_q[1]) begin
      active_d     = (state_q == ST_PLAY);
      sfx_sample_d = (state_q == ST_PLAY) ? rom_data : 16'sd0;
    end

    bgm_eff        = active_q ? (bgm_sample >>> 1) : bgm_sample;
    mix_sum        = {sfx_sample_q[15], sfx_sample_q} + {bgm_eff[15], bgm_eff};
    mix_d          = tick_pipe_q[2] ? sat16(mix_sum) : mix_q;
    sample_valid_d = tick_pipe_q[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      state_q        <= ST_IDLE;
      pending_q      <= 4'b0000;
      rom_addr_q     <= '0;
      remaining_q    <= 16'd0;
      playing_id_q   <= 2'd0;
      clip_done_q    <= 1'b0;
      tick_pipe_q    <= 3'b000;
      sfx_sample_q   <= 16'sd0;
      active_q       <= 1'b0;
      mix_q          <= 16'sd0;
      sample_valid_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      pending_q      <= pending_d;
      rom_addr_q     <= rom_addr_d;
      remaining_q    <= remaining_d;
      playing_id_q   <= playing_id_d;
      clip_done_q    <= clip_done_d;
      tick_pipe_q    <= tick_pipe_d;
      sfx_sample_q   <= sfx_sample_d;
      active_q       <= active_d;
      mix_q          <= mix_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign mix_out      = mix_q;
  assign sample_valid = sample_valid_q;
  assign sfx_busy     = (state_q == ST_PLAY);
  assign playing_id   = playing_id_q;
  assign clip_done    = clip_done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scenario bench for sfx_scheduler with an 8-cycle sample period and a ROM
// model returning data = address; mixed samples are checked via a queue.
module tb_sfx_scheduler;

  localparam int DIV = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         req = 4'b0000;
  logic               sfx_en = 1'b1;
  logic signed [15:0] bgm = 16'sd0;
  logic [15:0]        rom_addr;
  logic signed [15:0] rom_data = 16'sd0;
  logic signed [15:0] mix_out;
  logic               sample_valid;
  logic               sfx_busy;
  logic [1:0]         playing_id;
  logic               clip_done;

  logic               rom_force = 1'b0;
  logic signed [15:0] rom_force_val = 16'sd0;

  int total = 0;
  int bad = 0;
  int phase = 0;
  int done_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sfx_scheduler #(.SAMPLE_DIV(DIV), .ROM_AW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .sfx_en       (sfx_en),
    .bgm_sample   (bgm),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .mix_out      (mix_out),
    .sample_valid (sample_valid),
    .sfx_busy     (sfx_busy),
    .playing_id   (playing_id),
    .clip_done    (clip_done)
  );

  always @(posedge clk) rom_data <= rom_force ? rom_force_val : $signed(rom_addr);

  // Reference divider phase: the tick cycle is the one with phase == DIV-1.
  always @(posedge clk or posedge rst) begin
    if (rst) phase <= 0;
    else     phase <= (phase == DIV - 1) ? 0 : phase + 1;
  end

  always @(negedge clk) begin
    int e;
    if (clip_done === 1'b1) done_cnt++;
    if (sample_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (mix_out !== 16'(e)) begin
        bad++;
        $display("FAIL mix_out: got %0d want %0d", mix_out, e);
      end
    end
  end

  task automatic goto_tick();
    for (int i = 0; i <= DIV; i++) begin
      @(negedge clk);
      if (phase == DIV - 1) return;
    end
    total++; bad++;
    $display("FAIL tick_sync: phase %0d never reached %0d", phase, DIV - 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; bgm = 16'sd100;
    repeat (3) @(negedge clk);
    total++;
    if ({rom_addr, mix_out, sample_valid, sfx_busy, playing_id, clip_done} !== 37'd0) begin
      bad++;
      $display("FAIL reset_values: addr=%0d mix=%0d sv=%b busy=%b id=%0d done=%b want all 0",
               rom_addr, mix_out, sample_valid, sfx_busy, playing_id, clip_done);
    end
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    total++;
    if (mix_out !== 16'sd100 || sfx_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_passthrough: mix=%0d busy=%b want 100 0", mix_out, sfx_busy);
    end
    $display("info: reset test complete");
  endtask

  // Hit clip end to end, with a same-source retrigger at tick 100.
  task automatic test_single_clip();
    bgm = 16'sd100; done_cnt = 0;
    for (int t = 0; t <= 1601; t++) begin
      int a;
      goto_tick();
      req = (t == 0 || t == 100) ? 4'b0001 : 4'b0000;
      a = (t < 1600) ? t : 1599;
      exp_q.push_back((t < 1600) ? a + 50 : 100);
      @(negedge clk); req = 4'b0000;
      total++; if (rom_addr !== 16'(a)) begin bad++; $display("FAIL single_addr t=%0d: got %0d want %0d", t, rom_addr, a); end
      total++; if (sfx_busy !== (t < 1600)) begin bad++; $display("FAIL single_busy t=%0d: got %b want %b", t, sfx_busy, (t < 1600)); end
      total++; if (playing_id !== 2'd0) begin bad++; $display("FAIL single_id t=%0d: got %0d want 0", t, playing_id); end
      total++; if (clip_done !== (t == 1600)) begin bad++; $display("FAIL single_done t=%0d: got %b want %b", t, clip_done, (t == 1600)); end
    end
    repeat (DIV) @(negedge clk);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_samples: %0d expected samples never appeared", exp_q.size()); end
    $display("info: single clip test complete");
  endtask

  // Game-over preempts hit at tick 10, then effects are disabled mid-clip.
  task automatic test_preempt_disable();
    bgm = 16'sd100; done_cnt = 0;
    for (int t = 0; t <= 15; t++) begin
      int a;
      int exp_id;
      goto_tick();
      req = (t == 0) ? 4'b0001 : (t == 10) ? 4'b1000 : 4'b0000;
      a = (t < 10) ? t : 8000 + (t - 10);
      exp_id = (t < 10) ? 0 : 3;
      exp_q.push_back(a + 50);
      @(negedge clk); req = 4'b0000;
      total++; if (rom_addr !== 16'(a)) begin bad++; $display("FAIL preempt_addr t=%0d: got %0d want %0d", t, rom_addr, a); end
      total++; if (playing_id !== 2'(exp_id)) begin bad++; $display("FAIL preempt_id t=%0d: got %0d want %0d", t, playing_id, exp_id); end
      total++; if (clip_done !== 1'b0 || sfx_busy !== 1'b1) begin bad++; $display("FAIL preempt_flags t=%0d: done=%b busy=%b want 0 1", t, clip_done, sfx_busy); end
    end
    @(negedge clk); @(negedge clk); sfx_en = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      if (t == 2) sfx_en = 1'b1;
      goto_tick();
      exp_q.push_back(100);
      @(negedge clk);
      total++; if (sfx_busy !== 1'b0 || clip_done !== 1'b0) begin bad++; $display("FAIL disable_idle t=%0d: busy=%b done=%b want 0 0", t, sfx_busy, clip_done); end
      total++; if (rom_addr !== 16'd8005) begin bad++; $display("FAIL disable_addr_hold t=%0d: got %0d want 8005", t, rom_addr); end
    end
    repeat (DIV) @(negedge clk);
    total++; if (done_cnt != 0) begin bad++; $display("FAIL preempt_done_count: got %0d want 0", done_cnt); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL preempt_samples: %0d expected samples never appeared", exp_q.size()); end
    $display("info: preemption/disable test complete");
  endtask

  task automatic test_saturation();
    rom_force = 1'b1; rom_force_val = 16'sh7fff; bgm = 16'sh7fff;
    for (int t = 0; t <= 5; t++) begin
      goto_tick();
      req = (t == 0) ? 4'b0001 : 4'b0000;
      if (t == 3) begin rom_force_val = 16'sh8000; bgm = 16'sh8000; end
      exp_q.push_back((t < 3) ? 32767 : -32768);
      @(negedge clk); req = 4'b0000;
      total++; if (sfx_busy !== 1'b1 || rom_addr !== 16'(t)) begin bad++; $display("FAIL sat_play t=%0d: busy=%b addr=%0d want 1 %0d", t, sfx_busy, rom_addr, t); end
    end
    @(negedge clk); sfx_en = 1'b0;
    for (int t = 0; t <= 1; t++) begin
      goto_tick();
      bgm = 16'sd1000;
      exp_q.push_back(1000);
      @(negedge clk);
    end
    repeat (DIV) @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sat_samples: %0d expected samples never appeared", exp_q.size()); end
    sfx_en = 1'b1; rom_force = 1'b0;
    $display("info: saturation test complete");
  endtask

  // Level-up plays while miss and hit queue behind it; hit is cut by sfx_en=0.
  task automatic test_queue();
    bgm = -16'sd200; done_cnt = 0;
    for (int t = 0; t <= 6405; t++) begin
      int a;
      int exp_id;
      goto_tick();
      req = (t == 0) ? 4'b0100 : 4'b0000;
      if (t < 4800)      begin a = 3200 + t;        exp_id = 2; end
      else if (t < 6400) begin a = 1600 + t - 4800; exp_id = 1; end
      else               begin a = t - 6400;        exp_id = 0; end
      exp_q.push_back(a - 100);
      @(negedge clk); req = 4'b0000;
      total++; if (rom_addr !== 16'(a)) begin bad++; $display("FAIL queue_addr t=%0d: got %0d want %0d", t, rom_addr, a); end
      total++; if (playing_id !== 2'(exp_id) || sfx_busy !== 1'b1) begin bad++; $display("FAIL queue_id t=%0d: id=%0d busy=%b want %0d 1", t, playing_id, sfx_busy, exp_id); end
      total++; if (clip_done !== (t == 4800 || t == 6400)) begin bad++; $display("FAIL queue_done t=%0d: got %b", t, clip_done); end
      if (t == 5) begin @(negedge clk); req = 4'b0010; @(negedge clk); req = 4'b0000; end
      if (t == 6) begin @(negedge clk); req = 4'b0001; @(negedge clk); req = 4'b0000; end
    end
    @(negedge clk); sfx_en = 1'b0;
    for (int t = 0; t <= 1; t++) begin
      goto_tick();
      exp_q.push_back(-200);
      @(negedge clk);
      total++; if (sfx_busy !== 1'b0 || clip_done !== 1'b0 || rom_addr !== 16'd5) begin bad++; $display("FAIL queue_disable t=%0d: busy=%b done=%b addr=%0d want 0 0 5", t, sfx_busy, clip_done, rom_addr); end
    end
    sfx_en = 1'b1;
    repeat (DIV) @(negedge clk);
    total++; if (done_cnt != 2) begin bad++; $display("FAIL queue_done_count: got %0d want 2", done_cnt); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL queue_samples: %0d expected samples never appeared", exp_q.size()); end
    $display("info: queueing test complete");
  endtask

  task automatic test_async_reset();
    int n_first;
    bgm = 16'sd100;
    goto_tick(); req = 4'b1000;
    @(negedge clk); req = 4'b0000;
    repeat (3) goto_tick();
    @(posedge clk); #2; rst = 1'b1; #1;
    total++;
    if ({rom_addr, mix_out, sample_valid, sfx_busy, playing_id, clip_done} !== 37'd0) begin
      bad++;
      $display("FAIL async_reset: addr=%0d mix=%0d sv=%b busy=%b id=%0d done=%b want all 0",
               rom_addr, mix_out, sample_valid, sfx_busy, playing_id, clip_done);
    end
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    n_first = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (sample_valid === 1'b1) begin n_first = n; break; end
    end
    total++; if (n_first != DIV + 3) begin bad++; $display("FAIL first_sample_valid: got edge %0d want %0d", n_first, DIV + 3); end
    total++; if (mix_out !== 16'sd100 || sfx_busy !== 1'b0) begin bad++; $display("FAIL post_reset_mix: mix=%0d busy=%b want 100 0", mix_out, sfx_busy); end
    $display("info: async reset test complete");
  endtask

  initial begin
    test_reset();
    test_single_clip();
    test_preempt_disable();
    test_saturation();
    test_queue();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
